// File: rtl/clk_lock_sequencer.sv
// Reset/lock sequencer for the clock-wizard path: pulses the wizard reset, qualifies locked,
// releases downstream reset after a stable period, retries on failure. Optional: LOCK_LOSS_COUNTER_EN.
module clk_lock_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        locked,
  input  logic        rearm,
  output logic        mmcm_resetn,
  output logic        sys_reset,
  output logic        lock_fail,
  output logic [3:0]  retry_cnt,
  output logic [2:0]  state,
  output logic [15:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam logic [23:0] HOLD_LAST    = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LAST   = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  logic        locked_meta_q;
  logic        locked_s_q;
  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic        fail_q, fail_d;
  logic        mmcm_resetn_q, mmcm_resetn_d;
  logic        sys_reset_q, sys_reset_d;

  // State register, synchronizer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= S_HOLD;
      timer_q       <= '0;
      retry_q       <= '0;
      fail_q        <= 1'b0;
      mmcm_resetn_q <= 1'b0;
      sys_reset_q   <= 1'b1;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      fail_q        <= fail_d;
      mmcm_resetn_q <= mmcm_resetn_d;
      sys_reset_q   <= sys_reset_d;
    end
  end

  // Next-state logic; a failed attempt either retries via HOLD or gives up in FAIL
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_HOLD: begin
        if (timer_q == HOLD_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = S_STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = S_FAIL;
            retry_d = RETRY_MAX;
            fail_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            retry_d = retry_q + 4'd1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s_q) begin
          if (retry_q == RETRY_LAST) begin
            state_d = S_FAIL;
            retry_d = RETRY_MAX;
            fail_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            retry_d = retry_q + 4'd1;
          end
        end else if (timer_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        retry_d = '0;
        if (!locked_s_q) state_d = S_HOLD;
      end
      S_FAIL: begin
        if (rearm) begin
          state_d = S_HOLD;
          retry_d = '0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Outputs decoded from the next state so they move on the transition edge
  always_comb begin
    mmcm_resetn_d = !((state_d == S_HOLD) || (state_d == S_FAIL));
    sys_reset_d   = (state_d != S_RUN);
    timer_d       = (state_d != state_q) ? 24'd0 : timer_q + 24'd1;
  end

  assign mmcm_resetn = mmcm_resetn_q;
  assign sys_reset   = sys_reset_q;
  assign lock_fail   = fail_q;
  assign retry_cnt   = retry_q;
  assign state       = state_q;

`ifdef LOCK_LOSS_COUNTER_EN
  logic [15:0] loss_q;
  logic        loss_event;

  assign loss_event = (state_q == S_RUN) && !locked_s_q;

  // Saturating; survives rearm, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != 16'hFFFF)) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// Scenario bench for clk_lock_sequencer: expected output vectors are queued with their
// cycle number when stimulus is planned and compared when that cycle is reached.
module tb_clk_lock_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        locked = 1'b0;
  logic        rearm = 1'b0;
  logic        mmcm_resetn;
  logic        sys_reset;
  logic        lock_fail;
  logic [3:0]  retry_cnt;
  logic [2:0]  state;
  logic [15:0] loss_cnt;

  clk_lock_sequencer #(
    .HOLD_CYCLES  (4),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(20),
    .MAX_RETRIES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .locked     (locked),
    .rearm      (rearm),
    .mmcm_resetn(mmcm_resetn),
    .sys_reset  (sys_reset),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .state      (state),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Packed view: {state, mmcm_resetn, sys_reset, lock_fail, retry_cnt, loss_cnt}
  logic [25:0] obs;
  assign obs = {state, mmcm_resetn, sys_reset, lock_fail, retry_cnt, loss_cnt};

`ifdef LOCK_LOSS_COUNTER_EN
  localparam logic [15:0] LC1 = 16'd1;
`else
  localparam logic [15:0] LC1 = 16'd0;
`endif

  typedef struct {
    int          cyc;
    logic [25:0] vec;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  t0       = 0;

  function automatic logic [25:0] ev(input logic [2:0] st, input logic mr, input logic sr,
                                     input logic lf, input logic [3:0] rc, input logic [15:0] lc);
    return {st, mr, sr, lf, rc, lc};
  endfunction

  function automatic void push_exp(input int c, input logic [25:0] v);
    sb_t e;
    e.cyc = c;
    e.vec = v;
    sb_q.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    locked = 1'b0;
    rearm  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t0    = cyc;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== ev(0, 0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h expected=%h", obs, ev(0, 0, 1, 0, 0, 0));
    end else $display("check reset_state obs=%h ok", obs);
    locked = 1'b0;
  endtask

  task automatic test_normal_lock();
    do_reset();
    push_exp(t0 + 3,  ev(0, 0, 1, 0, 0, 0));
    push_exp(t0 + 4,  ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 11, ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 12, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 31, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 32, ev(3, 1, 0, 0, 0, 0));
    for (int k = 0; k < 60 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == t0 + 9) locked = 1'b1;
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL normal_lock cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check normal_lock cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL normal_lock pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_lock_loss();
    int tb = cyc;
    locked = 1'b0;
    push_exp(tb + 2,  ev(3, 1, 0, 0, 0, 0));
    push_exp(tb + 3,  ev(0, 0, 1, 0, 0, LC1));
    push_exp(tb + 6,  ev(0, 0, 1, 0, 0, LC1));
    push_exp(tb + 7,  ev(1, 1, 1, 0, 0, LC1));
    push_exp(tb + 8,  ev(2, 1, 1, 0, 0, LC1));
    push_exp(tb + 27, ev(2, 1, 1, 0, 0, LC1));
    push_exp(tb + 28, ev(3, 1, 0, 0, 0, LC1));
    for (int k = 0; k < 50 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == tb + 3) locked = 1'b1;
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL lock_loss cyc=%0d got=%h expected=%h at cyc=%0d", cyc - tb, obs, e.vec, e.cyc - tb);
        end else $display("check lock_loss cyc=%0d obs=%h ok", cyc - tb, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL lock_loss pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_timeout_retry();
    do_reset();
    push_exp(t0 + 3,   ev(0, 0, 1, 0, 0, 0));
    push_exp(t0 + 4,   ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 103, ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 104, ev(0, 0, 1, 0, 1, 0));
    push_exp(t0 + 107, ev(0, 0, 1, 0, 1, 0));
    push_exp(t0 + 108, ev(1, 1, 1, 0, 1, 0));
    for (int k = 0; k < 130 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL timeout_retry cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check timeout_retry cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_retry pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Continues from test_timeout_retry: second timeout exhausts retries, then rearm
  task automatic test_retry_exhaustion();
    push_exp(t0 + 207, ev(1, 1, 1, 0, 1, 0));
    push_exp(t0 + 208, ev(4, 0, 1, 1, 2, 0));
    push_exp(t0 + 220, ev(4, 0, 1, 1, 2, 0));
    push_exp(t0 + 221, ev(0, 0, 1, 0, 0, 0));
    push_exp(t0 + 224, ev(0, 0, 1, 0, 0, 0));
    push_exp(t0 + 225, ev(1, 1, 1, 0, 0, 0));
    for (int k = 0; k < 150 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == t0 + 220 || cyc == t0 + 222) rearm = 1'b1;
      if (cyc == t0 + 221 || cyc == t0 + 223) rearm = 1'b0;
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL retry_exhaustion cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check retry_exhaustion cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    rearm = 1'b0;
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL retry_exhaustion pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // locked_s rises on the very cycle the lock timeout expires
  task automatic test_timeout_tie();
    do_reset();
    push_exp(t0 + 103, ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 104, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 123, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 124, ev(3, 1, 0, 0, 0, 0));
    for (int k = 0; k < 150 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == t0 + 101) locked = 1'b1;
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL timeout_tie cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check timeout_tie cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_tie pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_stable_glitch();
    do_reset();
    push_exp(t0 + 12, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 24, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 25, ev(0, 0, 1, 0, 1, 0));
    push_exp(t0 + 29, ev(1, 1, 1, 0, 1, 0));
    push_exp(t0 + 30, ev(2, 1, 1, 0, 1, 0));
    push_exp(t0 + 49, ev(2, 1, 1, 0, 1, 0));
    push_exp(t0 + 50, ev(3, 1, 0, 0, 0, 0));
    for (int k = 0; k < 70 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == t0 + 9 || cyc == t0 + 25) locked = 1'b1;
      if (cyc == t0 + 22) locked = 1'b0;
      if (cyc >= t0 + 20 && cyc < t0 + 50) begin
        n_checks++;
        if (sys_reset !== 1'b1) begin
          n_fail++;
          $display("FAIL stable_glitch_sys_reset cyc=%0d got=%b expected=1", cyc - t0, sys_reset);
        end
      end
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL stable_glitch cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check stable_glitch cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL stable_glitch pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_exp(t0 + 12, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 27, ev(2, 1, 1, 0, 0, 0));
    for (int k = 0; k < 40 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (cyc == t0 + 9) locked = 1'b1;
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL reset_mid_pre cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check reset_mid_pre cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL reset_mid_pre pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== ev(0, 0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h expected=%h", obs, ev(0, 0, 1, 0, 0, 0));
    end else $display("check reset_mid_async obs=%h ok", obs);
    @(negedge clk);
    reset = 1'b0;
    t0    = cyc;
    push_exp(t0 + 3,  ev(0, 0, 1, 0, 0, 0));
    push_exp(t0 + 4,  ev(1, 1, 1, 0, 0, 0));
    push_exp(t0 + 5,  ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 24, ev(2, 1, 1, 0, 0, 0));
    push_exp(t0 + 25, ev(3, 1, 0, 0, 0, 0));
    for (int k = 0; k < 40 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (sb_q[0].cyc <= cyc) begin
        sb_t e = sb_q.pop_front();
        n_checks++;
        if (obs !== e.vec || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL reset_mid_restart cyc=%0d got=%h expected=%h at cyc=%0d", cyc - t0, obs, e.vec, e.cyc - t0);
        end else $display("check reset_mid_restart cyc=%0d obs=%h ok", cyc - t0, obs);
      end
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL reset_mid_restart pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_lock_loss();
    test_timeout_retry();
    test_retry_exhaustion();
    test_timeout_tie();
    test_stable_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_lock_sequencer.md
# clk_lock_sequencer

Reset and lock controller for the board clock-wizard path (IBUFDS → clock wizard → 200 MHz domain). It drives the wizard's active-low reset, qualifies its `locked` status, and holds downstream logic in reset until the clock has been continuously stable for a programmable period. It retries on lock timeout or lock loss, and latches a sticky failure after a bounded number of consecutive retries. It runs on a free-running reference clock that does not depend on the wizard output.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: cycles the wizard reset is held low per attempt (≥1).
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK before the attempt is abandoned (≥1).
- `STABLE_CYCLES`, 1024: cycles `locked` must stay continuously high before downstream reset releases (≥1).
- `MAX_RETRIES`, 3: consecutive failed attempts tolerated before FAIL (1..15).
- All cycle parameters < 2^24; the single internal timer is 24 bits.

Ports:
- `clk` in 1: free-running reference clock. One clock; no other clock domain in the block.
- `reset` in 1: asynchronous, active-high reset.
- `locked` in 1: wizard lock status, asynchronous to `clk`.
- `rearm` in 1: single-cycle pulse; leaves FAIL and restarts sequencing.
- `mmcm_resetn` out 1: active-low reset to the clock wizard.
- `sys_reset` out 1: active-high reset to the downstream 200 MHz logic.
- `lock_fail` out 1: sticky failure flag.
- `retry_cnt` out 4: consecutive failed attempts so far.
- `state` out 3: encoded state (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).
- `loss_cnt` out 16: lock-loss event count (see Configuration).

## Operation
- `locked` passes through a 2-FF synchronizer to give `locked_s`. Only `locked_s` is used.
- A single 24-bit timer clears on every state entry and increments each cycle while in the state.
- **HOLD:** `mmcm_resetn`=0, `sys_reset`=1. When timer = HOLD_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `mmcm_resetn`=1, `sys_reset`=1.
  - `locked_s`=1 → STABLE.
  - Otherwise, timer = LOCK_TIMEOUT-1 → failed attempt.
- **STABLE:** `mmcm_resetn`=1, `sys_reset`=1.
  - `locked_s`=0 → failed attempt.
  - Otherwise, timer = STABLE_CYCLES-1 → RUN.
- **RUN:** `mmcm_resetn`=1, `sys_reset`=0, `retry_cnt` cleared to 0.
  - `locked_s`=0 → HOLD. This is a lock-loss event; it does not count as a failed attempt.
- **Failed attempt:**
  - If `retry_cnt` = MAX_RETRIES-1 → FAIL, with `retry_cnt` set to MAX_RETRIES.
  - Otherwise `retry_cnt`++ and go to HOLD.
- **FAIL:** `mmcm_resetn`=0, `sys_reset`=1, `lock_fail`=1. `rearm` → HOLD, clearing `retry_cnt` and `lock_fail`.
- `rearm` is ignored in every state except FAIL.
- When RUN is entered, `retry_cnt` clears on that same edge.

## Timing
- All outputs are registered, decoded from the next-state value, so each output changes on the same edge as the state transition.
- Reset values: `mmcm_resetn`=0, `sys_reset`=1, `lock_fail`=0, `retry_cnt`=0, `state`=HOLD, `loss_cnt`=0, timer=0, synchronizer=0.
- After `reset` deasserts, `mmcm_resetn` stays low for exactly HOLD_CYCLES rising edges.
- Latency from a `locked` pin edge to `locked_s` is 2 cycles.
- Lock loss in RUN: `sys_reset` rises 3 cycles after `locked` falls, and `mmcm_resetn` falls on the same edge.
- A normal release has `sys_reset` falling HOLD_CYCLES + (cycles until `locked_s`=1) + STABLE_CYCLES edges after reset release.
- A `locked` glitch shorter than one `clk` period may be missed. A glitch that reaches `locked_s` during STABLE always aborts the attempt.
- If a timeout and `locked_s` rising coincide in WAIT_LOCK, `locked_s` wins and the block goes to STABLE.
- Asserting `reset` in any state immediately forces all reset values; a sequence in progress is discarded.

## Configuration
- Macro: `LOCK_LOSS_COUNTER_EN`.
- **Defined:** `loss_cnt` increments once per RUN→HOLD lock-loss event. It saturates at 0xFFFF and clears only on `reset`, not on `rearm`.
- **Undefined:** the counter is not built and `loss_cnt` is tied to 0. The port list is unchanged.

## Test plan
Every scenario uses HOLD_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=20, MAX_RETRIES=2.
- **Normal lock:** release reset and raise `locked` at cycle 10 → `mmcm_resetn` is low for 4 cycles, `state` goes 1→2 at cycle 12, `sys_reset` falls at cycle 32, `retry_cnt`=0.
- **Timeout retry:** hold `locked`=0 → WAIT_LOCK exits after 100 cycles, `retry_cnt`=1, HOLD re-entered with `mmcm_resetn` low for 4 cycles.
- **Retry exhaustion:** `locked`=0 forever → FAIL after the second timeout with `lock_fail`=1, `retry_cnt`=2, `mmcm_resetn`=0. A `rearm` pulse then gives `state`=HOLD, `lock_fail`=0, `retry_cnt`=0.
- **Glitch in STABLE:** drop `locked` for 3 cycles at STABLE timer=10 → back to HOLD with `retry_cnt`=1. `sys_reset` never deasserts.
- **Lock loss in RUN:** drop `locked` while in RUN → `sys_reset`=1 exactly 3 cycles later, `retry_cnt` stays 0, and `loss_cnt`=1 with the macro (0 without). Relock reaches RUN again.
- **Reset mid-operation:** assert `reset` in STABLE at timer=15 → all outputs at reset values the same cycle. On release, the full sequence restarts from HOLD.
